// File: rtl/ladybird_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ladybird_pkg
//  Description : Shared types and helpers for the ladybird bit-serial
//                add/subtract unit (FSM state encoding, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package ladybird_pkg;

   // Sequencer states of the serial adder
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_state_t;

   // Bit-counter width: max(1, clog2(width)) so WIDTH=1 still gets a 1-bit counter
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : ladybird_pkg
`default_nettype wire

// File: rtl/ladybird_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ladybird_full_adder
//  Description : Single-bit full adder; the only arithmetic element of the
//                serial adder, reused for every bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
module ladybird_full_adder
   import ladybird_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic c_in,
   output logic q,
   output logic c_out
);

   // Sum and majority carry of three input bits
   always_comb begin
      q     = x ^ y ^ c_in;
      c_out = (x & y) | (c_in & (x ^ y));
   end

endmodule : ladybird_full_adder
`default_nettype wire

// File: rtl/ladybird_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ladybird_serial_adder
//  Description : Bit-serial add/subtract unit. One full adder is sequenced
//                LSB-first over WIDTH cycles with a registered carry.
//                Operands arrive and results leave over valid/ready
//                handshakes. Subtraction is A + ~B + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ladybird_serial_adder
   import ladybird_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   // operand side
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   // result side
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic             out_carry,
   output logic             out_overflow
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   serial_state_t    state_q,        state_d;
   logic [WIDTH-1:0] a_sr_q,         a_sr_d;
   logic [WIDTH-1:0] b_sr_q,         b_sr_d;
   logic [WIDTH-1:0] res_sr_q,       res_sr_d;
   logic             carry_q,        carry_d;
   logic [CNT_W-1:0] cnt_q,          cnt_d;
   logic [WIDTH-1:0] out_q_q,        out_q_d;
   logic             out_carry_q,    out_carry_d;
   logic             out_overflow_q, out_overflow_d;
   logic             in_ready_q,     in_ready_d;
   logic             out_valid_q,    out_valid_d;

   // Full-adder connections and the result word after this cycle's shift
   logic             fa_q;
   logic             fa_c_out;
   logic [WIDTH-1:0] res_shift;

   // ------------------------------------------------------------------------
   // Shared full adder, fed from the LSBs of the operand shift registers
   // ------------------------------------------------------------------------
   ladybird_full_adder u_full_adder (
      .x     (a_sr_q[0]),
      .y     (b_sr_q[0]),
      .c_in  (carry_q),
      .q     (fa_q),
      .c_out (fa_c_out)
   );

   // ------------------------------------------------------------------------
   // Result shift: new sum bit enters at the MSB so that after WIDTH shifts
   // bit 0 of the result sits at bit 0 of the register.
   // ------------------------------------------------------------------------
   generate
      if (WIDTH == 1) begin : g_res_single
         assign res_shift = fa_q;
      end else begin : g_res_multi
         assign res_shift = {fa_q, res_sr_q[WIDTH-1:1]};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next-state logic: FSM sequencing, operand/result shifting, flag capture
   // ------------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      a_sr_d         = a_sr_q;
      b_sr_d         = b_sr_q;
      res_sr_d       = res_sr_q;
      carry_d        = carry_q;
      cnt_d          = cnt_q;
      out_q_d        = out_q_q;
      out_carry_d    = out_carry_q;
      out_overflow_d = out_overflow_q;

      case (state_q)
         IDLE: begin
            // in_ready is high throughout IDLE, so in_valid alone is the accept
            if (in_valid) begin
               a_sr_d  = in_a;
               b_sr_d  = in_sub ? ~in_b : in_b;
               carry_d = in_sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_shift;
            carry_d  = fa_c_out;
            if (cnt_q == CNT_LAST) begin
               // carry_q is the carry into the MSB on this last bit
               out_q_d        = res_shift;
               out_carry_d    = fa_c_out;
               out_overflow_d = carry_q ^ fa_c_out;
               state_d        = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            // Result held until the consumer takes it; no new accept here
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered from the next state
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // ------------------------------------------------------------------------
   // State registers with synchronous reset; any state returns to IDLE
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         a_sr_q         <= '0;
         b_sr_q         <= '0;
         res_sr_q       <= '0;
         carry_q        <= 1'b0;
         cnt_q          <= '0;
         out_q_q        <= '0;
         out_carry_q    <= 1'b0;
         out_overflow_q <= 1'b0;
         in_ready_q     <= 1'b1;
         out_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_sr_q         <= a_sr_d;
         b_sr_q         <= b_sr_d;
         res_sr_q       <= res_sr_d;
         carry_q        <= carry_d;
         cnt_q          <= cnt_d;
         out_q_q        <= out_q_d;
         out_carry_q    <= out_carry_d;
         out_overflow_q <= out_overflow_d;
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_q        = out_q_q;
   assign out_carry    = out_carry_q;
   assign out_overflow = out_overflow_q;

endmodule : ladybird_serial_adder
`default_nettype wire

// File: doc/ladybird_serial_adder.md
# ladybird_serial_adder

Bit-serial add/subtract unit that time-shares one `ladybird_full_adder` instance across all bit positions of a WIDTH-bit operation. It accepts an operand pair through a valid/ready handshake and sequences the full adder LSB-first, one bit per clock, with a registered carry. It returns the sum/difference with carry and signed-overflow flags through a second valid/ready handshake. It is the area-minimal arithmetic resource for control paths where latency is not critical.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal range ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  unit can accept an operand pair; high only in IDLE.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_sub`  in  1  0: A+B; 1: A−B, computed as A+~B+1.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_q`  out  WIDTH  result, modulo 2^WIDTH.
- `out_carry`  out  1  final carry-out. For subtract, 1 means no borrow (A ≥ B unsigned).
- `out_overflow`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - Latch `in_a` into shift register `a_sr`.
    - Latch `in_b` into `b_sr`; when `in_sub` = 1, latch `~in_b` instead.
    - Set carry register to `in_sub`.
    - Clear bit counter `cnt` to 0.
    - Go to RUN.
- **RUN**
  - Each cycle, drive the full adder with `x=a_sr[0]`, `y=b_sr[0]`, `c_in=carry`.
  - Shift `a_sr` and `b_sr` right by one.
  - Shift `q` into the result register from the MSB end.
  - Set carry to `c_out`.
  - On the cycle where `cnt == WIDTH-1`, capture `carry` (the carry into the MSB) to compute overflow, then go to DONE. Otherwise increment `cnt`.
  - `in_valid` is ignored.
- **DONE**
  - `out_valid` = 1.
  - `out_q`, `out_carry` and `out_overflow` are held stable until `out_valid & out_ready`, then the FSM goes to IDLE.
  - There is no accept in DONE; a new operand is taken only in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. The flags give both unsigned (`out_carry`) and signed (`out_overflow`) interpretations.
- `cnt` width is `max(1, $clog2(WIDTH))`.
- WIDTH=1 is legal: RUN lasts exactly one cycle, and overflow = `c_in` XOR `c_out`.
- **Reset:** `rst` in any state, including mid-RUN or DONE, forces IDLE at the next edge. The partial result is discarded.
  - Reset values: `in_ready`=1, `out_valid`=0, `out_q`=0, `out_carry`=0, `out_overflow`=0.
  - All internal registers are cleared.
- Output data registers change only on RUN→DONE; they are stable and known in every other state.

## Timing
- Input transfer on edge E0 → RUN cycles E1..E_WIDTH → `out_valid` = 1 in the cycle after E_WIDTH.
- Minimum latency: WIDTH+1 edges from input transfer to `out_valid`.
- `in_ready` = 0 from the cycle after E0 until the cycle after the output-transfer edge.
- Throughput: one operation per WIDTH+2 cycles when `out_ready` is held high.
- Full-adder path is combinational inside RUN; carry and result are registered every cycle.
- `out_ready` held low keeps DONE indefinitely with no change to outputs.

## Structure
- Shared package `ladybird_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_t`.
  - Width helper function for `cnt`.
- One sub-module: a single `ladybird_full_adder` instance, the only arithmetic in the block.
- Rest: FSM, counter, two operand shift registers, result shift register, carry/flag registers.

## Test plan
- WIDTH=8, add 0x5A + 0x3C, `out_ready`=1 → `out_q`=0x96, carry=0, overflow=1; `out_valid` asserted exactly 9 edges after accept.
- WIDTH=8, add 0xFF + 0x01 → `out_q`=0x00, carry=1, overflow=0.
- WIDTH=8, sub 0x10 − 0x20 → 0xF0, carry=0, overflow=0; sub 0x80 − 0x01 → 0x7F, carry=1, overflow=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` with new operands → outputs stable, `in_ready`=0, no new accept; release → one output transfer, then `in_ready`=1.
- Assert `rst` for one cycle at RUN cycle 3 → next cycle IDLE, `in_ready`=1, `out_valid`=0, `out_q`=0; a following 0x01+0x01 yields 0x02 unaffected by the aborted op.
- WIDTH=1 build: 1+1 → q=0, carry=1, overflow=1; 1−1 → q=0, carry=1, overflow=0; back-to-back ops with `in_valid`/`out_ready` tied high → one result every 3 cycles.
